// File: rtl/fractionned_divider.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics, one quotient bit per clock.
// Optional FRAC_DIV_EARLY_OUT_EN: special cases (x/0, overflow, |a|<|b|) skip the iteration phase.
module fractionned_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             signed_div,
  input  logic             enable,
  output logic [WIDTH-1:0] output_quotient,
  output logic [WIDTH-1:0] output_remainder,
  output logic             output_valid,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    count;
  logic             q_neg;
  logic             r_neg;
  logic             sp_zero;
  logic             sp_ovf;
`ifdef FRAC_DIV_EARLY_OUT_EN
  logic             sp_small;
`endif

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             is_ovf;
  logic [WIDTH+1:0] rem_shift;
  logic             ge;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_neg     = signed_div & input_a[WIDTH-1];
    b_neg     = signed_div & input_b[WIDTH-1];
    a_mag     = a_neg ? -input_a : input_a;
    b_mag     = b_neg ? -input_b : input_b;
    is_ovf    = signed_div && (input_a == {1'b1, {(WIDTH-1){1'b0}}}) && (input_b == '1);
    // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
    rem_shift = {rem, dvd[WIDTH-1]};
    ge        = rem_shift >= {2'b00, dsr};
    q_fix     = q_neg ? -dvd : dvd;
    r_fix     = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      output_quotient  <= '0;
      output_remainder <= '0;
      output_valid     <= 1'b0;
      busy             <= 1'b0;
      count            <= '0;
      dvd              <= '0;
      dsr              <= '0;
      a_raw            <= '0;
      rem              <= '0;
      q_neg            <= 1'b0;
      r_neg            <= 1'b0;
      sp_zero          <= 1'b0;
      sp_ovf           <= 1'b0;
`ifdef FRAC_DIV_EARLY_OUT_EN
      sp_small         <= 1'b0;
`endif
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= enable;
          if (enable) begin
            dvd     <= a_mag;
            dsr     <= b_mag;
            a_raw   <= input_a;
            rem     <= '0;
            count   <= '0;
            q_neg   <= a_neg ^ b_neg;
            r_neg   <= a_neg;
            sp_zero <= (input_b == '0);
            sp_ovf  <= is_ovf;
`ifdef FRAC_DIV_EARLY_OUT_EN
            sp_small <= (a_mag < b_mag);
            state    <= ((input_b == '0) || is_ovf || (a_mag < b_mag)) ? FIX : ITER;
`else
            state    <= ITER;
`endif
          end
        end
        ITER: begin
          rem   <= ge ? (rem_shift[WIDTH:0] - {1'b0, dsr}) : rem_shift[WIDTH:0];
          dvd   <= {dvd[WIDTH-2:0], ge};
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (sp_zero) begin
            output_quotient  <= '1;
            output_remainder <= a_raw;
          end else if (sp_ovf) begin
            output_quotient  <= a_raw;
            output_remainder <= '0;
`ifdef FRAC_DIV_EARLY_OUT_EN
          end else if (sp_small) begin
            output_quotient  <= '0;
            output_remainder <= a_raw;
`endif
          end else begin
            output_quotient  <= q_fix;
            output_remainder <= r_fix;
          end
          output_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fractionned_divider.sv
// Scoreboard bench for fractionned_divider: expected results/latencies queued at issue, checked by a monitor on output_valid.
module tb_fractionned_divider;

  localparam int unsigned W = 32;
`ifdef FRAC_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] input_a = '0;
  logic [W-1:0] input_b = '0;
  logic         signed_div = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] output_quotient;
  logic [W-1:0] output_remainder;
  logic         output_valid;
  logic         busy;

  fractionned_divider #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .input_a(input_a),
    .input_b(input_b),
    .signed_div(signed_div),
    .enable(enable),
    .output_quotient(output_quotient),
    .output_remainder(output_remainder),
    .output_valid(output_valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int unsigned  acc;
    int unsigned  lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input int unsigned acc);
    exp_t         e;
    logic [W-1:0] am, bm;
    bit           early;
    am = (s && a[W-1]) ? -a : a;
    bm = (s && b[W-1]) ? -b : b;
    if (b == 0) begin
      e.q = '1; e.r = a; early = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a; e.r = '0; early = 1'b1;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
      early = (am < bm);
    end else begin
      e.q = a / b;
      e.r = a % b;
      early = (a < b);
    end
    e.acc = acc;
    e.lat = (EARLY && early) ? 1 : W + 1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per valid pulse
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (output_valid) begin
        chk("valid_single_cycle", {31'b0, prev_valid}, '0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", output_quotient, e.q);
          chk("remainder", output_remainder, e.r);
          chk("latency", cyc - e.acc, e.lat);
        end
      end
      prev_valid = output_valid;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("idle_timeout", {31'b0, busy}, '0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clock);
    wait_idle();
    input_a    = a;
    input_b    = b;
    signed_div = s;
    enable     = 1'b1;
    sb.push_back(model(a, b, s, cyc + 1));
    @(negedge clock);
    enable     = 1'b0;
    input_a    = $urandom;
    input_b    = $urandom;
    signed_div = 1'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b;
    int unsigned  next_acc;

    repeat (3) @(negedge clock);
    chk("reset_quotient", output_quotient, '0);
    chk("reset_remainder", output_remainder, '0);
    chk("reset_valid", {31'b0, output_valid}, '0);
    chk("reset_busy", {31'b0, busy}, '0);
    reset = 1'b0;

    issue(32'd69, 32'd127, 1'b0);
    issue(32'd127, 32'd69, 1'b0);
    issue(-32'sd7, 32'd2, 1'b1);
    issue(32'd5, 32'd0, 1'b1);
    issue(32'd5, 32'd0, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    drain();

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(3))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(255);
        default: a = $urandom;
      endcase
      case ($urandom_range(4))
        0: b = '0;
        1: b = '1;
        2: b = $urandom_range(15);
        default: b = $urandom;
      endcase
      issue(a, b, 1'($urandom));
    end
    drain();

    // enable held high: acceptances every W+2 cycles, operands scrambled in between
    @(negedge clock);
    wait_idle();
    next_acc = cyc + 1;
    for (int i = 0; i < 125; i++) begin
      if (cyc + 1 == next_acc) begin
        input_a    = 32'd1000;
        input_b    = 32'd7;
        signed_div = 1'b0;
        sb.push_back(model(32'd1000, 32'd7, 1'b0, next_acc));
        next_acc  += W + 2;
      end else begin
        input_a    = $urandom;
        input_b    = $urandom;
        signed_div = 1'($urandom);
      end
      enable = 1'b1;
      @(negedge clock);
    end
    enable = 1'b0;
    drain();

    // abort mid-iteration: reset lands at edge N+10
    @(negedge clock);
    wait_idle();
    input_a    = 32'd1000;
    input_b    = 32'd7;
    signed_div = 1'b0;
    enable     = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, '0);
    chk("abort_quotient", output_quotient, '0);
    chk("abort_remainder", output_remainder, '0);
    chk("abort_valid", {31'b0, output_valid}, '0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("post_abort_quotient", output_quotient, '0);
    chk("post_abort_remainder", output_remainder, '0);
    issue(32'd1000, 32'd7, 1'b0);
    issue(32'd127, 32'd69, 1'b0);
    drain();

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
